// File: rtl/ifetch_master.sv
// Instruction-fetch bus master: one Avalon-style read per fetch, valid/ready delivery to decode.
// Optional IFETCH_BYTESWAP_EN reverses byte order of the returned word.
module ifetch_master #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_start,
  input  logic        flush,
  output logic [31:0] address,
  output logic        read,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        stall,
  output logic        fault
);

  // state   | meaning
  // S_IDLE  | no fetch in progress, ready to accept
  // S_REQ   | bus read outstanding, PC stalled
  // S_DONE  | instr held for decode
  // S_FAULT | misaligned or timed-out fetch, terminal until reset
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_FAULT} state_t;

  state_t      state_q, state_d;
  logic        discard_q, discard_d;
  logic [TW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0] address_d, instr_d, rdata_ord;
  logic        read_d, instr_valid_d, stall_d, fault_d;
  logic [3:0]  byteenable_d;
  logic        done_release, can_accept, misaligned, timeout_hit;

`ifdef IFETCH_BYTESWAP_EN
  assign rdata_ord = {readdata[7:0], readdata[15:8], readdata[23:16], readdata[31:24]};
`else
  assign rdata_ord = readdata;
`endif

  assign done_release = (state_q == S_DONE) && ((clk_enable && instr_ready) || flush);
  assign can_accept   = clk_enable && fetch_start && ((state_q == S_IDLE) || done_release);
  assign misaligned   = (fetch_pc[1:0] != 2'b00);
  assign cnt_inc      = cnt_q + TW'(1);
  assign timeout_hit  = (TIMEOUT != 0) && waitrequest && (cnt_inc == TW'(TIMEOUT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      discard_q   <= 1'b0;
      cnt_q       <= '0;
      address     <= '0;
      read        <= 1'b0;
      byteenable  <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      stall       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state_q     <= state_d;
      discard_q   <= discard_d;
      cnt_q       <= cnt_d;
      address     <= address_d;
      read        <= read_d;
      byteenable  <= byteenable_d;
      instr       <= instr_d;
      instr_valid <= instr_valid_d;
      stall       <= stall_d;
      fault       <= fault_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (can_accept) state_d = misaligned ? S_FAULT : S_REQ;
      S_REQ: begin
        if (!waitrequest)     state_d = (discard_q || flush) ? S_IDLE : S_DONE;
        else if (timeout_hit) state_d = S_FAULT;
      end
      S_DONE: begin
        if (can_accept)        state_d = misaligned ? S_FAULT : S_REQ;
        else if (done_release) state_d = S_IDLE;
      end
      default: state_d = S_FAULT;
    endcase
  end

  always_comb begin
    address_d     = address;
    read_d        = read;
    byteenable_d  = byteenable;
    instr_d       = instr;
    instr_valid_d = instr_valid;
    stall_d       = stall;
    fault_d       = fault;
    discard_d     = discard_q;
    cnt_d         = cnt_q;

    if (state_q == S_REQ) begin
      if (!waitrequest) begin
        read_d       = 1'b0;
        stall_d      = 1'b0;
        byteenable_d = 4'h0;
        if (discard_q || flush) begin
          discard_d = 1'b0;
        end else begin
          instr_d       = rdata_ord;
          instr_valid_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_inc;
        if (flush) discard_d = 1'b1;
      end
    end

    if (done_release) instr_valid_d = 1'b0;

    if (can_accept && !misaligned) begin
      address_d    = fetch_pc;
      read_d       = 1'b1;
      byteenable_d = 4'hF;
      stall_d      = 1'b1;
      cnt_d        = '0;
      discard_d    = 1'b0;
    end

    // Fault overrides everything; the bus read is abandoned on timeout.
    if (state_d == S_FAULT) begin
      fault_d       = 1'b1;
      read_d        = 1'b0;
      byteenable_d  = 4'h0;
      instr_valid_d = 1'b0;
      stall_d       = 1'b0;
    end
  end

endmodule

// File: tb/tb_ifetch_master.sv
// Directed bench for ifetch_master with a scoreboard of expected instruction words.
module tb_ifetch_master;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned TW      = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        clk_enable = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        fetch_start = 1'b0;
  logic        flush = 1'b0;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
  logic        instr_ready = 1'b0;
  logic [31:0] address, instr;
  logic        read, instr_valid, stall, fault;
  logic [3:0]  byteenable;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  ifetch_master #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .fetch_pc(fetch_pc), .fetch_start(fetch_start), .flush(flush),
    .address(address), .read(read), .byteenable(byteenable),
    .waitrequest(waitrequest), .readdata(readdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .stall(stall), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [31:0] d);
`ifdef IFETCH_BYTESWAP_EN
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    return d;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check_sb;
    chk("sb_pending", 32'(sb.size() > 0), 1);
    if (sb.size() > 0) chk("instr", instr, sb.pop_front());
  endtask

  // Accept a fetch (optionally acking the held word in the same cycle), run `waits` wait states.
  task automatic run_fetch(input logic [31:0] pc, input logic [31:0] data, input int waits,
                           input logic ack_prev);
    fetch_pc = pc; readdata = data; fetch_start = 1'b1; clk_enable = 1'b1;
    waitrequest = 1'b0; instr_ready = ack_prev;
    sb.push_back(model(data));
    step;
    fetch_start = 1'b0; instr_ready = 1'b0;
    for (int k = 1; k <= waits + 1; k++) begin
      chk("req_read", 32'(read), 1);
      chk("req_addr", address, pc);
      chk("req_be", 32'(byteenable), 32'hF);
      chk("req_stall", 32'(stall), 1);
      chk("req_valid", 32'(instr_valid), 0);
      waitrequest = (k <= waits);
      step;
    end
    waitrequest = 1'b0;
    chk("done_read", 32'(read), 0);
    chk("done_stall", 32'(stall), 0);
    chk("done_be", 32'(byteenable), 0);
    chk("done_valid", 32'(instr_valid), 1);
    chk("done_fault", 32'(fault), 0);
    check_sb;
  endtask

  task automatic deliver;
    instr_ready = 1'b1; clk_enable = 1'b1;
    step;
    instr_ready = 1'b0;
    chk("deliver_valid", 32'(instr_valid), 0);
  endtask

  initial begin
    #1;
    chk("rst_addr", address, 0);
    chk("rst_read", 32'(read), 0);
    chk("rst_be", 32'(byteenable), 0);
    chk("rst_instr", instr, 0);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fault", 32'(fault), 0);
    #12 reset = 1'b1;
    step;

    // clk_enable low blocks acceptance; flush in IDLE does nothing
    fetch_pc = 32'h0000_1000; fetch_start = 1'b1; clk_enable = 1'b0;
    step;
    chk("gated_read", 32'(read), 0);
    fetch_start = 1'b0; clk_enable = 1'b1; flush = 1'b1;
    step;
    flush = 1'b0;
    chk("idle_flush_read", 32'(read), 0);
    chk("idle_flush_valid", 32'(instr_valid), 0);

    run_fetch(32'hBFC0_0000, 32'h3C01_1234, 0, 1'b0);

    // held while clk_enable is low, released once enabled
    instr_ready = 1'b1; clk_enable = 1'b0;
    step;
    chk("hold_disabled", 32'(instr_valid), 1);
    clk_enable = 1'b1;
    step;
    instr_ready = 1'b0;
    chk("release_valid", 32'(instr_valid), 0);

    run_fetch(32'hBFC0_0004, 32'h8C22_0000, 3, 1'b0);
    run_fetch(32'hBFC0_0008, 32'h2442_0001, 0, 1'b1);

    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("done_flush_valid", 32'(instr_valid), 0);
    chk("done_flush_read", 32'(read), 0);

    // flush on the 2nd REQ cycle, completion two cycles later
    fetch_pc = 32'hBFC0_000C; readdata = 32'hDEAD_BEEF; fetch_start = 1'b1; waitrequest = 1'b1;
    step;
    fetch_start = 1'b0;
    chk("flush_req_read", 32'(read), 1);
    step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    step;
    waitrequest = 1'b0;
    step;
    chk("flush_cmpl_read", 32'(read), 0);
    chk("flush_cmpl_stall", 32'(stall), 0);
    chk("flush_cmpl_valid", 32'(instr_valid), 0);
    step;
    chk("flush_idle_valid", 32'(instr_valid), 0);
    chk("flush_no_fault", 32'(fault), 0);

    run_fetch(32'hBFC0_0010, 32'h1122_3344, 1, 1'b0);
    deliver;

    // flush coinciding with completion discards the word
    fetch_pc = 32'hBFC0_0014; readdata = 32'h0BAD_F00D; fetch_start = 1'b1; waitrequest = 1'b0;
    step;
    fetch_start = 1'b0; flush = 1'b1;
    step;
    flush = 1'b0;
    chk("coinc_valid", 32'(instr_valid), 0);
    chk("coinc_read", 32'(read), 0);
    step;
    chk("coinc_valid2", 32'(instr_valid), 0);

    run_fetch(32'hBFC0_0018, 32'hA5A5_5A5A, 0, 1'b0);
    flush = 1'b1; instr_ready = 1'b1;
    step;
    flush = 1'b0; instr_ready = 1'b0;
    chk("flush_ready_valid", 32'(instr_valid), 0);

    // asynchronous reset mid-REQ
    fetch_pc = 32'hBFC0_001C; fetch_start = 1'b1; waitrequest = 1'b1;
    step;
    fetch_start = 1'b0;
    chk("pre_rst_read", 32'(read), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_read", 32'(read), 0);
    chk("arst_addr", address, 0);
    chk("arst_be", 32'(byteenable), 0);
    chk("arst_stall", 32'(stall), 0);
    chk("arst_instr", instr, 0);
    #1 reset = 1'b1;
    waitrequest = 1'b0;
    step;
    chk("post_rst_read", 32'(read), 0);

    // misaligned PC
    fetch_pc = 32'hBFC0_0002; fetch_start = 1'b1;
    step;
    chk("mis_fault", 32'(fault), 1);
    chk("mis_read", 32'(read), 0);
    chk("mis_stall", 32'(stall), 0);
    fetch_pc = 32'hBFC0_0000;
    step;
    step;
    fetch_start = 1'b0;
    chk("mis_ignore_read", 32'(read), 0);
    chk("mis_sticky", 32'(fault), 1);

    reset = 1'b0;
    #1;
    chk("rst_clears_fault", 32'(fault), 0);
    reset = 1'b1;
    step;

    // timeout after TIMEOUT wait-state cycles
    fetch_pc = 32'hBFC0_0020; fetch_start = 1'b1; waitrequest = 1'b1;
    step;
    fetch_start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      chk("to_read", 32'(read), 1);
      chk("to_nofault", 32'(fault), 0);
      step;
    end
    chk("to_fault", 32'(fault), 1);
    chk("to_read_drop", 32'(read), 0);
    chk("to_stall", 32'(stall), 0);
    chk("to_valid", 32'(instr_valid), 0);
    waitrequest = 1'b0;

    chk("sb_drained", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
